// File: rtl/pipelined_adder.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_adder
// Purpose  : Width-bit add/subtract unit with the carry chain split into
//            Stages registered segments, valid/ready handshake on both sides.
// Revision : 1.0 - initial release
// ============================================================================
module pipelined_adder #(
    parameter int Width  = 32,
    parameter int Stages = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [Width-1:0] in1_i,
    input  logic [Width-1:0] in2_i,
    input  logic             carry_i,
    input  logic             sub_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [Width-1:0] sum_o,
    output logic             carry_o,
    output logic             overflow_o
);

    localparam int ChunkW = Width / Stages;
    localparam int Last   = Stages - 1;

    if (Stages < 1 || Stages > Width || (Width % Stages) != 0) begin : g_bad_cfg
        $error("pipelined_adder: Stages must divide Width and lie in 1..Width");
    end

    // Each stage carries the full operand pair (upper chunks act as skew
    // registers) and the partially assembled sum.
    logic [Width-1:0]  a_q [Stages];
    logic [Width-1:0]  b_q [Stages];
    logic [Width-1:0]  s_q [Stages];
    logic [Stages-1:0] c_q;
    logic [Stages-1:0] v_q;

    logic [Width-1:0]  a_d [Stages];
    logic [Width-1:0]  b_d [Stages];
    logic [Width-1:0]  s_d [Stages];
    logic [Stages-1:0] c_d;
    logic [Stages-1:0] v_d;

    logic [Width-1:0]  a_x [Stages];
    logic [Width-1:0]  b_x [Stages];
    logic [Width-1:0]  s_x [Stages];
    logic [Stages-1:0] c_x;
    logic [Stages-1:0] v_x;
    logic [ChunkW:0]   t_x [Stages];

    logic en;

    assign en      = ~valid_o | ready_i;
    assign ready_o = en;

    always_comb begin
        a_x[0] = in1_i;
        b_x[0] = sub_i ? ~in2_i : in2_i;
        s_x[0] = '0;
        c_x[0] = sub_i | carry_i;
        v_x[0] = valid_i & en;
        for (int k = 1; k < Stages; k++) begin
            a_x[k] = a_q[k-1];
            b_x[k] = b_q[k-1];
            s_x[k] = s_q[k-1];
            c_x[k] = c_q[k-1];
            v_x[k] = v_q[k-1];
        end
        for (int k = 0; k < Stages; k++) begin
            t_x[k] = {1'b0, a_x[k][k*ChunkW +: ChunkW]}
                   + {1'b0, b_x[k][k*ChunkW +: ChunkW]}
                   + {{ChunkW{1'b0}}, c_x[k]};
            a_d[k] = a_x[k];
            b_d[k] = b_x[k];
            s_d[k] = s_x[k];
            s_d[k][k*ChunkW +: ChunkW] = t_x[k][ChunkW-1:0];
            c_d[k] = t_x[k][ChunkW];
            v_d[k] = v_x[k];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            a_q <= '{default: '0};
            b_q <= '{default: '0};
            s_q <= '{default: '0};
            c_q <= '0;
            v_q <= '0;
        end else if (en) begin
            a_q <= a_d;
            b_q <= b_d;
            s_q <= s_d;
            c_q <= c_d;
            v_q <= v_d;
        end
    end

    assign valid_o    = v_q[Last];
    assign sum_o      = s_q[Last];
    assign carry_o    = c_q[Last];
    assign overflow_o = (a_q[Last][Width-1] == b_q[Last][Width-1])
                      & (s_q[Last][Width-1] != a_q[Last][Width-1]);

endmodule
`default_nettype wire

// File: tb/tb_pipelined_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipelined_adder
// Purpose  : Directed self-checking bench for pipelined_adder in three shapes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipelined_adder;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // 8-bit / 2-stage instance
    logic       va_i, ra_o, ca_i, sa_i, va_o, ra_i, ca_o, oa_o;
    logic [7:0] a1_i, a2_i, as_o;
    // 8-bit / 4-stage instance
    logic       vb_i, rb_o, cb_i, sb_i, vb_o, rb_i, cb_o, ob_o;
    logic [7:0] b1_i, b2_i, bs_o;
    // 32-bit / 4-stage instance
    logic        vc_i, rc_o, cc_i, sc_i, vc_o, rc_i, cc_o, oc_o;
    logic [31:0] c1_i, c2_i, cs_o;

    pipelined_adder #(.Width(8), .Stages(2)) u_a (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(va_i), .ready_o(ra_o),
        .in1_i(a1_i), .in2_i(a2_i), .carry_i(ca_i), .sub_i(sa_i),
        .valid_o(va_o), .ready_i(ra_i), .sum_o(as_o), .carry_o(ca_o),
        .overflow_o(oa_o));

    pipelined_adder #(.Width(8), .Stages(4)) u_b (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(vb_i), .ready_o(rb_o),
        .in1_i(b1_i), .in2_i(b2_i), .carry_i(cb_i), .sub_i(sb_i),
        .valid_o(vb_o), .ready_i(rb_i), .sum_o(bs_o), .carry_o(cb_o),
        .overflow_o(ob_o));

    pipelined_adder #(.Width(32), .Stages(4)) u_c (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(vc_i), .ready_o(rc_o),
        .in1_i(c1_i), .in2_i(c2_i), .carry_i(cc_i), .sub_i(sc_i),
        .valid_o(vc_o), .ready_i(rc_i), .sum_o(cs_o), .carry_o(cc_o),
        .overflow_o(oc_o));

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] bp_exp [5];

    initial begin
        rst_n = 1'b0;
        {va_i, ca_i, sa_i, vb_i, cb_i, sb_i, vc_i, cc_i, sc_i} = '0;
        {ra_i, rb_i, rc_i} = 3'b111;
        a1_i = '0; a2_i = '0; b1_i = '0; b2_i = '0; c1_i = '0; c2_i = '0;
        bp_exp[0] = 32'h0101_0101;
        bp_exp[1] = 32'h1212_1212;
        bp_exp[2] = 32'h2323_2323;
        bp_exp[3] = 32'h3434_3434;
        bp_exp[4] = 32'h0000_0000;

        repeat (2) @(posedge clk);
        #1;
        check("rst_valid_a", va_o, 0);
        check("rst_ready_a", ra_o, 1);
        check("rst_sum_b",   bs_o, 0);
        check("rst_valid_c", vc_o, 0);
        check("rst_flags_c", {cc_o, oc_o}, 0);
        rst_n = 1'b1;
        tick();
        check("post_rst_ready_c", rc_o, 1);

        // 8/2: carry out, then two subtractions
        va_i = 1; a1_i = 8'hFF; a2_i = 8'h01; ca_i = 0; sa_i = 0;
        tick();
        check("a_latency", va_o, 0);
        a1_i = 8'h05; a2_i = 8'h07; ca_i = 1; sa_i = 1;
        tick();
        check("a0_res", {va_o, as_o, ca_o, oa_o}, {1'b1, 8'h00, 1'b1, 1'b0});
        a1_i = 8'h80; a2_i = 8'h01; ca_i = 0; sa_i = 1;
        tick();
        check("a1_res", {va_o, as_o, ca_o, oa_o}, {1'b1, 8'hFE, 1'b0, 1'b0});
        va_i = 0;
        tick();
        check("a2_res", {va_o, as_o, ca_o, oa_o}, {1'b1, 8'h7F, 1'b1, 1'b1});
        tick();
        check("a_empty", va_o, 0);

        // 8/4: carry ripples across every chunk boundary
        vb_i = 1; b1_i = 8'h7F; b2_i = 8'h00; cb_i = 1; sb_i = 0;
        tick();
        vb_i = 0;
        for (int k = 1; k <= 3; k++) begin
            check("b_latency", vb_o, 0);
            tick();
        end
        check("b_res", {vb_o, bs_o, cb_o, ob_o}, {1'b1, 8'h80, 1'b0, 1'b1});
        tick();
        check("b_empty", vb_o, 0);

        // 32/4: back-to-back throughput
        for (int k = 1; k <= 12; k++) begin
            if (k <= 8) begin
                vc_i = 1; c1_i = 32'(k - 1); c2_i = 32'h0000_FFFF;
            end else begin
                vc_i = 0;
            end
            tick();
            check("tp_valid", vc_o, (k >= 4 && k <= 11) ? 1 : 0);
            check("tp_ready", rc_o, 1);
            if (k >= 4 && k <= 11)
                check("tp_sum", {cs_o, cc_o}, {32'(k - 4) + 32'h0000_FFFF, 1'b0});
        end

        // 32/4: fill with downstream stalled, hold, then drain
        rc_i = 0;
        for (int j = 0; j < 4; j++) begin
            vc_i = 1; c1_i = 32'(j) * 32'h1111_1111; c2_i = 32'h0101_0101;
            tick();
        end
        c1_i = 32'hFFFF_FFFF; c2_i = 32'h0000_0001;
        for (int h = 0; h < 3; h++) begin
            check("bp_hold", {vc_o, rc_o, cs_o}, {1'b1, 1'b0, bp_exp[0]});
            if (h < 2) tick();
        end
        rc_i = 1;
        #1;
        check("bp_ready_now", rc_o, 1);
        tick();
        vc_i = 0;
        for (int j = 1; j < 5; j++) begin
            check("bp_drain", {vc_o, cs_o}, {1'b1, bp_exp[j]});
            tick();
        end
        check("bp_last_carry_gone", vc_o, 0);

        // 32/4: asynchronous reset with operations in flight
        for (int j = 0; j < 4; j++) begin
            vc_i = 1; c1_i = 32'(j + 1); c2_i = 32'h0000_0100;
            tick();
        end
        vc_i = 0;
        check("rf_before", {vc_o, cs_o}, {1'b1, 32'h0000_0101});
        #2 rst_n = 1'b0;
        #1;
        check("rf_cleared", {vc_o, cs_o, cc_o, oc_o}, 0);
        check("rf_ready", rc_o, 1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            check("rf_silent", vc_o, 0);
        end
        vc_i = 1; c1_i = 32'h0000_0003; c2_i = 32'h0000_0004;
        tick();
        vc_i = 0;
        repeat (3) tick();
        check("rf_resume", {vc_o, cs_o}, {1'b1, 32'h0000_0007});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
